// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg
//   Shared definitions for the MEMORY pipeline stage: rd write-source
//   encodings, the data-bus controller state type and a word-alignment
//   helper used to build the data-memory address.
package mem_stage_pkg;

    // rd write-back source select carried down the pipeline
    localparam logic [1:0] RD_SRC_ALU = 2'b00;
    localparam logic [1:0] RD_SRC_MEM = 2'b01;
    localparam logic [1:0] RD_SRC_PC4 = 2'b10;

    // Data-bus controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_DONE = 2'b10
    } bus_state_t;

    // Clear the byte offset so the bus always sees a word address
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl
//   Drives the req/ack data-memory handshake for the instruction currently
//   held in the M register: request generation, wait-state timeout, load-data
//   capture and the busy indication that freezes the M register.
//   Ports:
//     clk, rst_n      clock, async active-low reset
//     i_mem_op        M instruction is a load or a store
//     i_new_instr     M register takes a new instruction (or bubble) this edge
//     i_dmem_ack      bus transaction complete
//     i_dmem_rdata    load data, valid with i_dmem_ack
//     o_dmem_req      bus request
//     o_busy          access outstanding, M register must hold
//     o_fault         timeout abort for the current instruction
//     o_load_value    load result presented to the rd data mux
module mem_bus_ctrl
    import mem_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_mem_op,
    input  logic        i_new_instr,
    input  logic        i_dmem_ack,
    input  logic [31:0] i_dmem_rdata,
    output logic        o_dmem_req,
    output logic        o_busy,
    output logic        o_fault,
    output logic [31:0] o_load_value
);

    localparam logic        TO_ENABLE = (TIMEOUT_CYCLES != 0);
    localparam logic [31:0] TO_LAST   = (TIMEOUT_CYCLES == 0) ? 32'd0 : 32'(TIMEOUT_CYCLES - 1);

    bus_state_t  r_state;
    logic [31:0] r_count;
    logic [31:0] r_load_data;
    logic        r_fault;
    logic        w_timeout_hit;

    // The request rises combinationally from IDLE so a zero-wait memory can
    // ack in the very first cycle the instruction sits in M.
    assign o_dmem_req    = i_mem_op & (r_state != ST_DONE);
    // An ack in the final allowed cycle wins over the timeout.
    assign w_timeout_hit = TO_ENABLE & o_dmem_req & ~i_dmem_ack & (r_count == TO_LAST);
    assign o_busy        = o_dmem_req & ~i_dmem_ack & ~w_timeout_hit;
    assign o_fault       = r_fault | w_timeout_hit;

    // Once DONE the bus is released, so the captured word must be used; an
    // abort returns zero instead of whatever is floating on the read bus.
    assign o_load_value = (r_state == ST_DONE) ? r_load_data :
                          (w_timeout_hit ? 32'd0 : i_dmem_rdata);

    // A new M instruction always restarts from IDLE, which lets back-to-back
    // memory ops raise a fresh request in the cycle right after completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_count     <= 32'd0;
            r_load_data <= 32'd0;
            r_fault     <= 1'b0;
        end else if (i_new_instr) begin
            r_state <= ST_IDLE;
            r_count <= 32'd0;
            r_fault <= 1'b0;
        end else if (o_dmem_req & (i_dmem_ack | w_timeout_hit)) begin
            r_state     <= ST_DONE;
            r_count     <= 32'd0;
            r_load_data <= w_timeout_hit ? 32'd0 : i_dmem_rdata;
            if (w_timeout_hit) begin
                r_fault <= 1'b1;
            end
        end else if (o_dmem_req) begin
            r_state <= ST_REQ;
            r_count <= r_count + 32'd1;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage
//   MEMORY pipeline stage. Registers the execute-stage outputs into the M
//   register, performs word loads/stores over a req/ack bus and produces the
//   rd write-back data and the branch/jump redirect.
//   Ports:
//     clk, rst_n                    clock, async active-low reset
//     *_e                           execute-stage results entering M
//     stall_m, flush_m              hazard unit hold / bubble requests
//     alu_res_m, rd_m               forwarding / hazard information
//     rd_write_m, rd_data_m         write-back request and data
//     pc_write_m, pc_target_m       redirect to fetch
//     busy_m, mem_fault_m           access outstanding / access aborted
//     dmem_*                        data-memory req/ack bus
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pc_write_e,
    input  logic        rd_write_e,
    input  logic [1:0]  rd_write_src_e,
    input  logic        mem_write_e,
    input  logic [4:0]  rd_e,
    input  logic [31:0] pc_e,
    input  logic [31:0] alu_res_e,
    input  logic [31:0] mem_data_e,
    input  logic        stall_m,
    input  logic        flush_m,
    output logic [31:0] alu_res_m,
    output logic [4:0]  rd_m,
    output logic        rd_write_m,
    output logic [31:0] rd_data_m,
    output logic        pc_write_m,
    output logic [31:0] pc_target_m,
    output logic        busy_m,
    output logic        mem_fault_m,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack
);

    logic        r_pc_write;
    logic        r_rd_write;
    logic [1:0]  r_rd_src;
    logic        r_mem_write;
    logic [4:0]  r_rd;
    logic [31:0] r_pc;
    logic [31:0] r_alu_res;
    logic [31:0] r_mem_data;
    logic        r_flush_pending;

    logic        w_mem_op;
    logic        w_busy;
    logic        w_fault;
    logic        w_do_bubble;
    logic        w_do_load;
    logic        w_new_instr;
    logic [31:0] w_load_value;

    assign w_mem_op    = r_mem_write | (r_rd_src == RD_SRC_MEM);
    // A flush that arrives while the bus is busy is remembered and applied
    // as soon as the access completes; flush beats stall.
    assign w_do_bubble = ~w_busy & (flush_m | r_flush_pending);
    assign w_do_load   = ~w_busy & ~(flush_m | r_flush_pending) & ~stall_m;
    assign w_new_instr = w_do_bubble | w_do_load;

    mem_bus_ctrl #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_bus_ctrl (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_mem_op     (w_mem_op),
        .i_new_instr  (w_new_instr),
        .i_dmem_ack   (dmem_ack),
        .i_dmem_rdata (dmem_rdata),
        .o_dmem_req   (dmem_req),
        .o_busy       (w_busy),
        .o_fault      (w_fault),
        .o_load_value (w_load_value)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc_write      <= 1'b0;
            r_rd_write      <= 1'b0;
            r_rd_src        <= RD_SRC_ALU;
            r_mem_write     <= 1'b0;
            r_rd            <= 5'd0;
            r_pc            <= 32'd0;
            r_alu_res       <= 32'd0;
            r_mem_data      <= 32'd0;
            r_flush_pending <= 1'b0;
        end else if (w_busy) begin
            if (flush_m) begin
                r_flush_pending <= 1'b1;
            end
        end else if (w_do_bubble) begin
            r_pc_write      <= 1'b0;
            r_rd_write      <= 1'b0;
            r_rd_src        <= RD_SRC_ALU;
            r_mem_write     <= 1'b0;
            r_rd            <= 5'd0;
            r_pc            <= 32'd0;
            r_alu_res       <= 32'd0;
            r_mem_data      <= 32'd0;
            r_flush_pending <= 1'b0;
        end else if (w_do_load) begin
            r_pc_write  <= pc_write_e;
            r_rd_write  <= rd_write_e;
            r_rd_src    <= rd_write_src_e;
            r_mem_write <= mem_write_e;
            r_rd        <= rd_e;
            r_pc        <= pc_e;
            r_alu_res   <= alu_res_e;
            r_mem_data  <= mem_data_e;
        end
    end

    // Reserved source 11 falls back to the ALU result.
    always_comb begin
        rd_data_m = r_alu_res;
        case (r_rd_src)
            RD_SRC_MEM: rd_data_m = w_load_value;
            RD_SRC_PC4: rd_data_m = r_pc + 32'd4;
            default:    rd_data_m = r_alu_res;
        endcase
    end

    assign alu_res_m   = r_alu_res;
    assign rd_m        = r_rd;
    assign rd_write_m  = r_rd_write & (r_rd != 5'd0) & ~w_fault;
    assign pc_write_m  = r_pc_write;
    assign pc_target_m = r_alu_res;
    assign busy_m      = w_busy;
    assign mem_fault_m = w_fault;
    assign dmem_we     = dmem_req & r_mem_write;
    assign dmem_addr   = word_align(r_alu_res);
    assign dmem_wdata  = r_mem_data;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage
//   Directed bench for mem_stage with a 4-cycle bus timeout. Inputs change
//   1 time unit after the rising edge; outputs are observed on the falling
//   edge.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pc_write_e = 1'b0;
    logic        rd_write_e = 1'b0;
    logic [1:0]  rd_write_src_e = 2'b00;
    logic        mem_write_e = 1'b0;
    logic [4:0]  rd_e = 5'd0;
    logic [31:0] pc_e = 32'd0;
    logic [31:0] alu_res_e = 32'd0;
    logic [31:0] mem_data_e = 32'd0;
    logic        stall_m = 1'b0;
    logic        flush_m = 1'b0;
    logic [31:0] alu_res_m;
    logic [4:0]  rd_m;
    logic        rd_write_m;
    logic [31:0] rd_data_m;
    logic        pc_write_m;
    logic [31:0] pc_target_m;
    logic        busy_m;
    logic        mem_fault_m;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata = 32'd0;
    logic        dmem_ack = 1'b0;

    int nCompared = 0;
    int nMismatched = 0;

    mem_stage #(
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc_write_e     (pc_write_e),
        .rd_write_e     (rd_write_e),
        .rd_write_src_e (rd_write_src_e),
        .mem_write_e    (mem_write_e),
        .rd_e           (rd_e),
        .pc_e           (pc_e),
        .alu_res_e      (alu_res_e),
        .mem_data_e     (mem_data_e),
        .stall_m        (stall_m),
        .flush_m        (flush_m),
        .alu_res_m      (alu_res_m),
        .rd_m           (rd_m),
        .rd_write_m     (rd_write_m),
        .rd_data_m      (rd_data_m),
        .pc_write_m     (pc_write_m),
        .pc_target_m    (pc_target_m),
        .busy_m         (busy_m),
        .mem_fault_m    (mem_fault_m),
        .dmem_req       (dmem_req),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_wdata     (dmem_wdata),
        .dmem_rdata     (dmem_rdata),
        .dmem_ack       (dmem_ack)
    );

    always #5 clk = ~clk;

    // Step to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Step to the falling edge where outputs are observed
    task automatic sample();
        @(negedge clk);
    endtask

    // Drive one execute-stage instruction
    task automatic applyStimulus(input logic pcw, input logic rdw, input logic [1:0] src,
                                 input logic mw, input logic [4:0] rd, input logic [31:0] pc,
                                 input logic [31:0] alu, input logic [31:0] data);
        pc_write_e     = pcw;
        rd_write_e     = rdw;
        rd_write_src_e = src;
        mem_write_e    = mw;
        rd_e           = rd;
        pc_e           = pc;
        alu_res_e      = alu;
        mem_data_e     = data;
    endtask

    task automatic applyNop();
        applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0);
    endtask

    // Everything must read zero while reset is held
    task automatic test_reset();
        #2;
        nCompared++; if (dmem_req !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_req: got %0h expected 0", dmem_req); end
        nCompared++; if (busy_m !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_busy: got %0h expected 0", busy_m); end
        nCompared++; if (rd_data_m !== 32'd0) begin nMismatched++; $display("[TB] FAIL reset_rd_data: got %h expected 0", rd_data_m); end
        nCompared++; if (alu_res_m !== 32'd0) begin nMismatched++; $display("[TB] FAIL reset_alu_res: got %h expected 0", alu_res_m); end
        nCompared++; if ({rd_write_m, pc_write_m, mem_fault_m, dmem_we} !== 4'b0) begin nMismatched++; $display("[TB] FAIL reset_ctrl: got %b expected 0000", {rd_write_m, pc_write_m, mem_fault_m, dmem_we}); end
        nCompared++; if (dmem_addr !== 32'd0 || dmem_wdata !== 32'd0) begin nMismatched++; $display("[TB] FAIL reset_bus: got addr %h wdata %h expected 0 0", dmem_addr, dmem_wdata); end
        tick();
        tick();
        rst_n = 1'b1;
        sample();
        nCompared++; if (dmem_req !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_release_req: got %0h expected 0", dmem_req); end
    endtask

    // Load acked in its first cycle: no stall, data passes straight through
    task automatic test_zero_wait_load();
        applyStimulus(1'b0, 1'b1, 2'b01, 1'b0, 5'd5, 32'h1000, 32'h100, 32'd0);
        tick();
        applyNop();
        dmem_ack = 1'b1;
        dmem_rdata = 32'hDEADBEEF;
        sample();
        nCompared++; if (busy_m !== 1'b0) begin nMismatched++; $display("[TB] FAIL zw_busy: got %0h expected 0", busy_m); end
        nCompared++; if (dmem_req !== 1'b1) begin nMismatched++; $display("[TB] FAIL zw_req: got %0h expected 1", dmem_req); end
        nCompared++; if (rd_data_m !== 32'hDEADBEEF) begin nMismatched++; $display("[TB] FAIL zw_rd_data: got %h expected deadbeef", rd_data_m); end
        nCompared++; if (rd_write_m !== 1'b1) begin nMismatched++; $display("[TB] FAIL zw_rd_write: got %0h expected 1", rd_write_m); end
        nCompared++; if (dmem_addr !== 32'h100) begin nMismatched++; $display("[TB] FAIL zw_addr: got %h expected 00000100", dmem_addr); end
        nCompared++; if (dmem_we !== 1'b0) begin nMismatched++; $display("[TB] FAIL zw_we: got %0h expected 0", dmem_we); end
        tick();
        dmem_ack = 1'b0;
        sample();
        nCompared++; if (dmem_req !== 1'b0 || rd_m !== 5'd0) begin nMismatched++; $display("[TB] FAIL zw_advance: got req %0h rd %0d expected 0 0", dmem_req, rd_m); end
    endtask

    // Store with three wait states; M must hold while the next op waits in E
    task automatic test_store_wait();
        int busyCycles;
        busyCycles = 0;
        applyStimulus(1'b0, 1'b0, 2'b00, 1'b1, 5'd0, 32'h2000, 32'h203, 32'h12345678);
        tick();
        applyStimulus(1'b0, 1'b1, 2'b00, 1'b0, 5'd7, 32'h2004, 32'h55, 32'd0);
        for (int i = 1; i <= 4; i++) begin
            dmem_ack = (i == 4);
            sample();
            if (busy_m === 1'b1) busyCycles++;
            nCompared++; if (dmem_addr !== 32'h200 || dmem_wdata !== 32'h12345678) begin nMismatched++; $display("[TB] FAIL st_bus_c%0d: got addr %h wdata %h expected 00000200 12345678", i, dmem_addr, dmem_wdata); end
            nCompared++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1) begin nMismatched++; $display("[TB] FAIL st_req_c%0d: got req %0h we %0h expected 1 1", i, dmem_req, dmem_we); end
            nCompared++; if (alu_res_m !== 32'h203) begin nMismatched++; $display("[TB] FAIL st_hold_c%0d: got %h expected 00000203", i, alu_res_m); end
            if (i == 4) begin
                nCompared++; if (mem_fault_m !== 1'b0) begin nMismatched++; $display("[TB] FAIL st_fault: got %0h expected 0", mem_fault_m); end
            end
            tick();
        end
        dmem_ack = 1'b0;
        nCompared++; if (busyCycles != 3) begin nMismatched++; $display("[TB] FAIL st_busy_cycles: got %0d expected 3", busyCycles); end
        sample();
        nCompared++; if (rd_m !== 5'd7 || rd_data_m !== 32'h55 || dmem_req !== 1'b0) begin nMismatched++; $display("[TB] FAIL st_next: got rd %0d data %h req %0h expected 7 00000055 0", rd_m, rd_data_m, dmem_req); end
        applyNop();
        tick();
    endtask

    // Load that is never acked aborts after four request cycles
    task automatic test_timeout();
        int reqCycles;
        reqCycles = 0;
        applyStimulus(1'b0, 1'b1, 2'b01, 1'b0, 5'd9, 32'h3000, 32'h300, 32'd0);
        tick();
        applyStimulus(1'b0, 1'b1, 2'b00, 1'b0, 5'd3, 32'h3004, 32'h77, 32'd0);
        dmem_rdata = 32'hCAFEF00D;
        for (int i = 1; i <= 6; i++) begin
            sample();
            if (dmem_req === 1'b1) reqCycles++;
            if (i < 4) begin
                nCompared++; if (busy_m !== 1'b1 || mem_fault_m !== 1'b0) begin nMismatched++; $display("[TB] FAIL to_wait_c%0d: got busy %0h fault %0h expected 1 0", i, busy_m, mem_fault_m); end
            end
            if (i == 4) begin
                nCompared++; if (mem_fault_m !== 1'b1) begin nMismatched++; $display("[TB] FAIL to_fault: got %0h expected 1", mem_fault_m); end
                nCompared++; if (rd_write_m !== 1'b0) begin nMismatched++; $display("[TB] FAIL to_rd_write: got %0h expected 0", rd_write_m); end
                nCompared++; if (rd_data_m !== 32'd0) begin nMismatched++; $display("[TB] FAIL to_rd_data: got %h expected 0", rd_data_m); end
                nCompared++; if (busy_m !== 1'b0) begin nMismatched++; $display("[TB] FAIL to_busy: got %0h expected 0", busy_m); end
            end
            tick();
        end
        nCompared++; if (reqCycles != 4) begin nMismatched++; $display("[TB] FAIL to_req_cycles: got %0d expected 4", reqCycles); end
        sample();
        nCompared++; if (rd_m !== 5'd3 || rd_write_m !== 1'b1 || mem_fault_m !== 1'b0) begin nMismatched++; $display("[TB] FAIL to_advance: got rd %0d wr %0h fault %0h expected 3 1 0", rd_m, rd_write_m, mem_fault_m); end
        dmem_rdata = 32'd0;
        applyNop();
        tick();
    endtask

    // Flush seen while busy turns the following M load into a bubble
    task automatic test_flush_busy();
        applyStimulus(1'b0, 1'b1, 2'b01, 1'b0, 5'd6, 32'h4000, 32'h400, 32'd0);
        tick();
        applyStimulus(1'b1, 1'b1, 2'b00, 1'b0, 5'd8, 32'h4004, 32'h99, 32'd0);
        flush_m = 1'b1;
        sample();
        nCompared++; if (busy_m !== 1'b1) begin nMismatched++; $display("[TB] FAIL fl_busy_c1: got %0h expected 1", busy_m); end
        tick();
        flush_m = 1'b0;
        dmem_rdata = 32'h11112222;
        for (int i = 2; i <= 4; i++) begin
            dmem_ack = (i == 4);
            sample();
            if (i < 4) begin
                nCompared++; if (busy_m !== 1'b1) begin nMismatched++; $display("[TB] FAIL fl_busy_c%0d: got %0h expected 1", i, busy_m); end
            end else begin
                nCompared++; if (busy_m !== 1'b0 || rd_data_m !== 32'h11112222 || rd_write_m !== 1'b1) begin nMismatched++; $display("[TB] FAIL fl_ack: got busy %0h data %h wr %0h expected 0 11112222 1", busy_m, rd_data_m, rd_write_m); end
            end
            tick();
        end
        dmem_ack = 1'b0;
        sample();
        nCompared++; if (rd_write_m !== 1'b0 || pc_write_m !== 1'b0 || rd_m !== 5'd0 || dmem_req !== 1'b0) begin nMismatched++; $display("[TB] FAIL fl_bubble: got wr %0h pcw %0h rd %0d req %0h expected 0 0 0 0", rd_write_m, pc_write_m, rd_m, dmem_req); end
        tick();
        sample();
        nCompared++; if (rd_m !== 5'd8 || pc_write_m !== 1'b1 || pc_target_m !== 32'h99) begin nMismatched++; $display("[TB] FAIL fl_reload: got rd %0d pcw %0h tgt %h expected 8 1 00000099", rd_m, pc_write_m, pc_target_m); end
        applyNop();
        tick();
    endtask

    // pc+4 wrap, redirect, stall hold, rd=0 suppression, flush beats stall
    task automatic test_jal();
        applyStimulus(1'b1, 1'b1, 2'b10, 1'b0, 5'd1, 32'hFFFFFFFC, 32'h40, 32'd0);
        tick();
        sample();
        nCompared++; if (rd_data_m !== 32'd0) begin nMismatched++; $display("[TB] FAIL jal_rd_data: got %h expected 0", rd_data_m); end
        nCompared++; if (pc_write_m !== 1'b1 || pc_target_m !== 32'h40) begin nMismatched++; $display("[TB] FAIL jal_redirect: got pcw %0h tgt %h expected 1 00000040", pc_write_m, pc_target_m); end
        nCompared++; if (rd_write_m !== 1'b1) begin nMismatched++; $display("[TB] FAIL jal_rd_write: got %0h expected 1", rd_write_m); end
        stall_m = 1'b1;
        applyStimulus(1'b0, 1'b1, 2'b00, 1'b0, 5'd4, 32'h5000, 32'h88, 32'd0);
        tick();
        sample();
        nCompared++; if (pc_write_m !== 1'b1 || pc_target_m !== 32'h40 || rd_m !== 5'd1) begin nMismatched++; $display("[TB] FAIL jal_stall: got pcw %0h tgt %h rd %0d expected 1 00000040 1", pc_write_m, pc_target_m, rd_m); end
        stall_m = 1'b0;
        applyStimulus(1'b1, 1'b1, 2'b10, 1'b0, 5'd0, 32'hFFFFFFFC, 32'h40, 32'd0);
        tick();
        sample();
        nCompared++; if (rd_write_m !== 1'b0 || pc_write_m !== 1'b1) begin nMismatched++; $display("[TB] FAIL jal_rd0: got wr %0h pcw %0h expected 0 1", rd_write_m, pc_write_m); end
        stall_m = 1'b1;
        flush_m = 1'b1;
        tick();
        sample();
        nCompared++; if (pc_write_m !== 1'b0 || pc_target_m !== 32'd0) begin nMismatched++; $display("[TB] FAIL flush_over_stall: got pcw %0h tgt %h expected 0 0", pc_write_m, pc_target_m); end
        stall_m = 1'b0;
        flush_m = 1'b0;
        applyNop();
        tick();
    endtask

    // Consecutive loads, then a stalled load that must use captured data
    task automatic test_back_to_back();
        applyStimulus(1'b0, 1'b1, 2'b01, 1'b0, 5'd2, 32'h6000, 32'h10, 32'd0);
        tick();
        applyStimulus(1'b0, 1'b1, 2'b01, 1'b0, 5'd3, 32'h6004, 32'h20, 32'd0);
        dmem_ack = 1'b1;
        dmem_rdata = 32'h0000000A;
        sample();
        nCompared++; if (dmem_addr !== 32'h10 || rd_data_m !== 32'h0000000A) begin nMismatched++; $display("[TB] FAIL b2b_first: got addr %h data %h expected 00000010 0000000a", dmem_addr, rd_data_m); end
        tick();
        applyStimulus(1'b0, 1'b1, 2'b01, 1'b0, 5'd4, 32'h6008, 32'h30, 32'd0);
        dmem_rdata = 32'h0000000B;
        sample();
        nCompared++; if (dmem_req !== 1'b1 || dmem_addr !== 32'h20 || rd_data_m !== 32'h0000000B) begin nMismatched++; $display("[TB] FAIL b2b_second: got req %0h addr %h data %h expected 1 00000020 0000000b", dmem_req, dmem_addr, rd_data_m); end
        tick();
        stall_m = 1'b1;
        dmem_rdata = 32'h0000000C;
        sample();
        nCompared++; if (rd_data_m !== 32'h0000000C || rd_m !== 5'd4) begin nMismatched++; $display("[TB] FAIL b2b_third: got data %h rd %0d expected 0000000c 4", rd_data_m, rd_m); end
        tick();
        dmem_ack = 1'b0;
        dmem_rdata = 32'h00000BAD;
        sample();
        nCompared++; if (dmem_req !== 1'b0 || rd_data_m !== 32'h0000000C || rd_write_m !== 1'b1) begin nMismatched++; $display("[TB] FAIL b2b_done_hold: got req %0h data %h wr %0h expected 0 0000000c 1", dmem_req, rd_data_m, rd_write_m); end
        stall_m = 1'b0;
        applyNop();
        tick();
        sample();
        nCompared++; if (dmem_req !== 1'b0 || rd_m !== 5'd0) begin nMismatched++; $display("[TB] FAIL b2b_drain: got req %0h rd %0d expected 0 0", dmem_req, rd_m); end
        dmem_rdata = 32'd0;
    endtask

    // Reset in the middle of a waiting load clears everything at once
    task automatic test_async_reset();
        applyStimulus(1'b0, 1'b1, 2'b01, 1'b0, 5'd5, 32'h7000, 32'h600, 32'd0);
        tick();
        applyNop();
        sample();
        nCompared++; if (dmem_req !== 1'b1 || busy_m !== 1'b1) begin nMismatched++; $display("[TB] FAIL ar_pre: got req %0h busy %0h expected 1 1", dmem_req, busy_m); end
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        nCompared++; if (dmem_req !== 1'b0 || busy_m !== 1'b0) begin nMismatched++; $display("[TB] FAIL ar_req: got req %0h busy %0h expected 0 0", dmem_req, busy_m); end
        nCompared++; if (alu_res_m !== 32'd0 || rd_m !== 5'd0 || rd_data_m !== 32'd0 || dmem_addr !== 32'd0) begin nMismatched++; $display("[TB] FAIL ar_regs: got alu %h rd %0d data %h addr %h expected all 0", alu_res_m, rd_m, rd_data_m, dmem_addr); end
        nCompared++; if ({rd_write_m, pc_write_m, mem_fault_m, dmem_we} !== 4'b0) begin nMismatched++; $display("[TB] FAIL ar_ctrl: got %b expected 0000", {rd_write_m, pc_write_m, mem_fault_m, dmem_we}); end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            sample();
            nCompared++; if (dmem_req !== 1'b0 || busy_m !== 1'b0) begin nMismatched++; $display("[TB] FAIL ar_post_c%0d: got req %0h busy %0h expected 0 0", i, dmem_req, busy_m); end
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        $display("[TB] mem_stage directed bench start");
        test_reset();
        test_zero_wait_load();
        test_store_wait();
        test_timeout();
        test_flush_busy();
        test_jal();
        test_back_to_back();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEMORY (_m) pipeline stage: consumes the execute-stage outputs, registers them into the M pipeline register and performs word load/store on a req/ack data-memory bus with wait states.
- Returns alu_res_m to execute for forwarding.
- Reports busy to the hazard control unit.
- Produces the final rd write data and the branch/jump redirect for the writeback and fetch stages.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles dmem_req is held without dmem_ack before abort; 0 disables timeout.

Ports:
- clk  input  1  clock
- rst_n  input  1  async active-low reset
- pc_write_e  input  1  branch/jump taken
- rd_write_e  input  1  register write enable
- rd_write_src_e  input  2  rd source: 00 ALU, 01 load, 10 pc+4, 11 ALU (reserved)
- mem_write_e  input  1  store
- rd_e  input  5  destination register
- pc_e  input  32  instruction PC
- alu_res_e  input  32  ALU result / address / target
- mem_data_e  input  32  store data
- stall_m  input  1  hazard: hold M register
- flush_m  input  1  hazard: load bubble into M register
- alu_res_m  output  32  registered ALU result (forwarding to execute)
- rd_m  output  5  registered rd (hazard unit)
- rd_write_m  output  1  effective register write enable
- rd_data_m  output  32  result to writeback
- pc_write_m  output  1  redirect request
- pc_target_m  output  32  redirect target (= alu_res_m)
- busy_m  output  1  memory op in progress, stage must hold
- mem_fault_m  output  1  timeout abort occurred for current instruction
- dmem_req  output  1  bus request
- dmem_we  output  1  1 = store
- dmem_addr  output  32  {alu_res_m[31:2], 2'b00}
- dmem_wdata  output  32  store data
- dmem_rdata  input  32  load data, valid with dmem_ack
- dmem_ack  input  1  transaction complete

Behaviour:
- Reset (async, rst_n low): all M registers 0, FSM IDLE, timeout counter 0, flush_pending 0, load-data register 0.
  - All outputs are 0 during and after reset; dmem_req drops immediately, even mid-transaction.
- Memory op: mem_op_m = mem_write_m | (rd_write_src_m == 01).
- FSM states and transitions:
  - IDLE: not servicing.
  - REQ: dmem_req=1, dmem_we=mem_write_m; addr and wdata held stable until ack.
  - DONE: access finished for the current instruction.
  - IDLE->REQ combinationally, whenever mem_op_m is set and the op is not yet done; the state register reflects REQ from the next edge.
  - REQ->DONE on dmem_ack (capture dmem_rdata for loads) or on timeout.
  - DONE->IDLE when the M register loads a new instruction.
- dmem_req = mem_op_m & (state != DONE).
- busy_m = dmem_req & ~dmem_ack & ~timeout_hit. This is a combinational ack->busy path, so zero-wait memory costs no stall cycle.
- Timeout: counter increments each cycle dmem_req & ~dmem_ack and resets on leaving REQ. timeout_hit when count == TIMEOUT_CYCLES-1.
  - On hit: load data = 0, mem_fault_m set until the next M register load, rd_write_m forced 0.
- Pipeline register advance, per edge:
  - if busy_m: hold; a flush_m seen this cycle sets flush_pending.
  - else if flush_m | flush_pending: bubble (all control 0, data 0); clear flush_pending.
  - else if stall_m: hold.
  - else: load the E inputs.
  - Flush and stall together with busy low: flush wins.
- rd_data_m:
  - 00/11: alu_res_m
  - 01: load-data register when state==DONE, else dmem_rdata (same-cycle ack)
  - 10: pc_m + 4, wrapping modulo 2^32
- rd_write_m = rd_write_reg & (rd_m != 0) & ~mem_fault_m.
- pc_write_m is registered and valid while the instruction is in M; it stays asserted on stall.
- A store that also has rd_write set: rd_write honoured with source as encoded.
- Back-to-back memory ops:
  - A new op loaded while in DONE re-enters the REQ path the same cycle. No idle gap is required, and no dmem_req drop is guaranteed between ops.
  - The bus samples a new transaction at each ack.

Decomposition:
- Shared pipeline package: rd_write_src encodings (RD_SRC_ALU=2'b00, RD_SRC_MEM=2'b01, RD_SRC_PC4=2'b10) and FSM state constants (IDLE/REQ/DONE).
- One natural sub-module: mem_bus_ctrl, holding the FSM, timeout counter, load-data capture and busy/req generation.
- The M pipeline register and rd_data mux stay in mem_stage.

Test Plan:
- Zero-wait load: E loads rd_write_src=01, alu_res=0x100, rd=5; dmem_ack same cycle with rdata=0xDEADBEEF -> busy_m never high, rd_data_m=0xDEADBEEF, rd_write_m=1, dmem_addr=0x100.
- 3-wait store: mem_write=1, alu_res=0x203, data=0x12345678, ack on 4th req cycle -> dmem_addr=0x200, busy_m high 3 cycles, wdata stable throughout, M register holds.
- Timeout: TIMEOUT_CYCLES=4, load, ack never comes -> dmem_req high exactly 4 cycles, mem_fault_m=1, rd_write_m=0, rd_data_m=0, pipeline advances.
- Flush during busy: flush_m pulsed in cycle 1 of a 3-wait load -> transaction completes with ack, next edge loads bubble (rd_write_m=0, pc_write_m=0) rather than the E inputs.
- JAL-style: rd_write_src=10, pc=0xFFFFFFFC, pc_write=1, alu_res=0x40 -> rd_data_m=0x00000000, pc_target_m=0x40, pc_write_m=1; writes with rd=0 give rd_write_m=0.
- Async reset asserted mid-REQ -> dmem_req, busy_m and all outputs 0 immediately; after release, no spurious request.
